// File: rtl/ram_loader.sv
// ram_loader: owns the write side of the system RAM port.
// After reset it fills every location with FILL. It then passes the CPU bus
// straight through. While an ioctl download is active it writes the downloaded
// bytes into RAM and holds the CPU off with RDY low.
module ram_loader #(
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    DATA_WIDTH = 8,
   parameter int                    DEPTH      = 1024,
   parameter logic [DATA_WIDTH-1:0] FILL       = 8'hFF
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_cpu_cs,
   input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
   input  logic                  i_cpu_rw,
   input  logic [DATA_WIDTH-1:0] i_cpu_dout,
   output logic                  o_cpu_rdy,
   input  logic                  i_ioctl_download,
   input  logic                  i_ioctl_wr,
   input  logic [ADDR_WIDTH-1:0] i_ioctl_addr,
   input  logic [DATA_WIDTH-1:0] i_ioctl_dout,
   output logic                  o_ioctl_wait,
   output logic                  o_ram_cs,
   output logic [ADDR_WIDTH-1:0] o_ram_addr,
   output logic                  o_ram_rw,
   output logic [DATA_WIDTH-1:0] o_ram_din,
   output logic                  o_load_done,
   output logic                  o_load_err,
   output logic [ADDR_WIDTH:0]   o_load_count
);

   typedef enum logic [1:0] {S_CLEAR, S_PASS, S_LOAD, S_DRAIN} state_t;

   localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] C_ONE   = (ADDR_WIDTH+1)'(1);

   state_t                r_state,      w_state_next;
   logic [ADDR_WIDTH:0]   r_cnt,        w_cnt_next;
   logic                  r_wcs,        w_wcs_next;
   logic                  r_wrw,        w_wrw_next;
   logic [ADDR_WIDTH-1:0] r_waddr,      w_waddr_next;
   logic [DATA_WIDTH-1:0] r_wdin,       w_wdin_next;
   logic                  r_cpu_rdy,    w_cpu_rdy_next;
   logic                  r_load_done,  w_load_done_next;
   logic                  r_load_err,   w_load_err_next;
   logic [ADDR_WIDTH:0]   r_load_count, w_load_count_next;
   logic                  r_hold_full,  w_hold_full_next;
   logic [ADDR_WIDTH-1:0] r_hold_addr,  w_hold_addr_next;
   logic [DATA_WIDTH-1:0] r_hold_data,  w_hold_data_next;
   logic                  w_ioctl_wait;
   logic                  w_hold_in_range;

   assign w_hold_in_range = ({1'b0, r_hold_addr} < C_DEPTH);

   // State and datapath registers; everything returns to idle values on reset.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state      <= S_CLEAR;
         r_cnt        <= '0;
         r_wcs        <= 1'b0;
         r_wrw        <= 1'b1;
         r_waddr      <= '0;
         r_wdin       <= '0;
         r_cpu_rdy    <= 1'b0;
         r_load_done  <= 1'b0;
         r_load_err   <= 1'b0;
         r_load_count <= '0;
         r_hold_full  <= 1'b0;
         r_hold_addr  <= '0;
         r_hold_data  <= '0;
      end else begin
         r_state      <= w_state_next;
         r_cnt        <= w_cnt_next;
         r_wcs        <= w_wcs_next;
         r_wrw        <= w_wrw_next;
         r_waddr      <= w_waddr_next;
         r_wdin       <= w_wdin_next;
         r_cpu_rdy    <= w_cpu_rdy_next;
         r_load_done  <= w_load_done_next;
         r_load_err   <= w_load_err_next;
         r_load_count <= w_load_count_next;
         r_hold_full  <= w_hold_full_next;
         r_hold_addr  <= w_hold_addr_next;
         r_hold_data  <= w_hold_data_next;
      end
   end

   // Next-state logic: clear sweep, pass-through, byte capture and write-out.
   always_comb begin
      w_state_next      = r_state;
      w_cnt_next        = r_cnt;
      w_wcs_next        = 1'b0;            // internal writes last one cycle
      w_wrw_next        = 1'b1;
      w_waddr_next      = r_waddr;
      w_wdin_next       = r_wdin;
      w_cpu_rdy_next    = r_cpu_rdy;
      w_load_done_next  = 1'b0;
      w_load_err_next   = r_load_err;
      w_load_count_next = r_load_count;
      w_hold_full_next  = r_hold_full;
      w_hold_addr_next  = r_hold_addr;
      w_hold_data_next  = r_hold_data;
      w_ioctl_wait      = 1'b0;
      case (r_state)
         S_CLEAR: begin
            // A download requested now is held off until the sweep is over.
            w_ioctl_wait = i_ioctl_download;
            if (r_cnt < C_DEPTH) begin
               w_wcs_next   = 1'b1;
               w_wrw_next   = 1'b0;
               w_waddr_next = r_cnt[ADDR_WIDTH-1:0];
               w_wdin_next  = FILL;
               w_cnt_next   = r_cnt + C_ONE;
            end else begin
               w_state_next   = S_PASS;
               w_cpu_rdy_next = 1'b1;
            end
         end
         S_PASS: begin
            // Bytes cannot be taken until LOAD is entered on the next edge.
            w_ioctl_wait   = i_ioctl_download;
            w_cpu_rdy_next = 1'b1;
            if (i_ioctl_download) begin
               w_state_next      = S_LOAD;
               w_cpu_rdy_next    = 1'b0;
               w_load_err_next   = 1'b0;
               w_load_count_next = '0;
            end
         end
         S_LOAD, S_DRAIN: begin
            w_ioctl_wait = r_hold_full;
            // A held byte is written (or dropped if out of range) this edge.
            if (r_hold_full) begin
               w_hold_full_next = 1'b0;
               if (w_hold_in_range) begin
                  w_wcs_next   = 1'b1;
                  w_wrw_next   = 1'b0;
                  w_waddr_next = r_hold_addr;
                  w_wdin_next  = r_hold_data;
                  if (r_load_count < C_DEPTH) begin
                     w_load_count_next = r_load_count + C_ONE;
                  end
               end else begin
                  w_load_err_next = 1'b1;
               end
            end
            if (r_state == S_LOAD) begin
               if (i_ioctl_wr) begin
                  if (!r_hold_full) begin
                     w_hold_full_next = 1'b1;
                     w_hold_addr_next = i_ioctl_addr;
                     w_hold_data_next = i_ioctl_dout;
                  end else begin
                     w_load_err_next = 1'b1;   // overrun: strobe ignored wait
                  end
               end
               if (!i_ioctl_download) begin
                  w_state_next = S_DRAIN;
               end
            end else if (!r_hold_full) begin
               w_state_next     = S_PASS;
               w_cpu_rdy_next   = 1'b1;
               w_load_done_next = 1'b1;
            end
         end
         default: begin
            w_state_next = S_CLEAR;
         end
      endcase
   end

   // The CPU owns the RAM port combinationally only while passing through.
   assign o_ram_cs     = (r_state == S_PASS) ? i_cpu_cs   : r_wcs;
   assign o_ram_addr   = (r_state == S_PASS) ? i_cpu_addr : r_waddr;
   assign o_ram_rw     = (r_state == S_PASS) ? i_cpu_rw   : r_wrw;
   assign o_ram_din    = (r_state == S_PASS) ? i_cpu_dout : r_wdin;

   // Wait is masked during reset so the port looks idle while held.
   assign o_ioctl_wait = i_reset_n & w_ioctl_wait;
   assign o_cpu_rdy    = r_cpu_rdy;
   assign o_load_done  = r_load_done;
   assign o_load_err   = r_load_err;
   assign o_load_count = r_load_count;

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: stimulus pushes expected RAM writes into a
// queue, a monitor pops and compares each write the DUT presents.
module tb_ram_loader;
   localparam int AW    = 16;
   localparam int DW    = 8;
   localparam int DEPTH = 1024;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cpu_cs, cpu_rw, cpu_rdy;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_dout;
   logic          dl, wr, io_wait;
   logic [AW-1:0] io_addr;
   logic [DW-1:0] io_dout;
   logic          ram_cs, ram_rw;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic          done, err;
   logic [AW:0]   count;

   logic [DW-1:0] mem [0:65535];
   wr_t           exp_q[$];
   wr_t           mon_e;
   int            n_cmp = 0;
   int            n_bad = 0;

   always #5 clk = ~clk;

   ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .FILL(8'hFF)) dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_cpu_cs(cpu_cs), .i_cpu_addr(cpu_addr), .i_cpu_rw(cpu_rw), .i_cpu_dout(cpu_dout),
      .o_cpu_rdy(cpu_rdy),
      .i_ioctl_download(dl), .i_ioctl_wr(wr), .i_ioctl_addr(io_addr), .i_ioctl_dout(io_dout),
      .o_ioctl_wait(io_wait),
      .o_ram_cs(ram_cs), .o_ram_addr(ram_addr), .o_ram_rw(ram_rw), .o_ram_din(ram_din),
      .o_load_done(done), .o_load_err(err), .o_load_count(count)
   );

   // Behavioural RAM that the DUT port drives.
   always @(posedge clk) begin
      if (ram_cs === 1'b1 && ram_rw === 1'b0) mem[ram_addr] <= ram_din;
   end

   // Monitor: every presented write must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && ram_cs === 1'b1 && ram_rw === 1'b0) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_write: got addr %h data %h, required no write", ram_addr, ram_din);
         end else begin
            mon_e = exp_q.pop_front();
            if (ram_addr !== mon_e.a || ram_din !== mon_e.d) begin
               n_bad++;
               $display("FAIL ram_write: got addr %h data %h, required addr %h data %h",
                        ram_addr, ram_din, mon_e.a, mon_e.d);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_clear();
      wr_t e;
      for (int i = 0; i < DEPTH; i++) begin
         e.a = AW'(i);
         e.d = 8'hFF;
         exp_q.push_back(e);
      end
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_cpu_rdy"}, 32'(cpu_rdy), 0);
      chk({tag, "_ioctl_wait"}, 32'(io_wait), 0);
      chk({tag, "_load_done"}, 32'(done), 0);
      chk({tag, "_load_err"}, 32'(err), 0);
      chk({tag, "_load_count"}, 32'(count), 0);
      chk({tag, "_ram_cs"}, 32'(ram_cs), 0);
      chk({tag, "_ram_rw"}, 32'(ram_rw), 1);
   endtask

   task automatic wait_ready();
      int k = 0;
      while (io_wait === 1'b1 && k < 10) begin
         tick();
         k++;
      end
      if (io_wait !== 1'b0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_timeout: got ioctl_wait %b, required 0 within 10 cycles", io_wait);
      end
   endtask

   task automatic send_byte(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_write);
      wr_t e;
      wait_ready();
      wr = 1'b1;
      io_addr = a;
      io_dout = d;
      if (expect_write) begin
         e.a = a;
         e.d = d;
         exp_q.push_back(e);
      end
      $display("ioctl byte: addr %h data %h write_expected %0d", a, d, expect_write);
      tick();
      wr = 1'b0;
      chk("cpu_rdy_low_in_load", 32'(cpu_rdy), 0);
   endtask

   task automatic end_download(input string tag);
      int pulses = 0;
      dl = 1'b0;
      repeat (8) begin
         tick();
         if (done === 1'b1) pulses++;
      end
      chk({tag, "_done_pulses"}, 32'(pulses), 1);
      chk({tag, "_cpu_rdy_after"}, 32'(cpu_rdy), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      wr_t e;
      rst_n = 1'b0; cpu_cs = 1'b0; cpu_rw = 1'b1; cpu_addr = '0; cpu_dout = '0;
      dl = 1'b0; wr = 1'b0; io_addr = '0; io_dout = '0;
      repeat (3) tick();
      reset_checks("reset");

      // Power-up clear: DEPTH fill writes, RDY rises on edge DEPTH+1.
      push_clear();
      rst_n = 1'b1;
      repeat (DEPTH) tick();
      chk("cpu_rdy_edge_depth", 32'(cpu_rdy), 0);
      tick();
      chk("cpu_rdy_edge_depth_plus1", 32'(cpu_rdy), 1);
      chk("clear_writes_left", exp_q.size(), 0);
      chk("mem_0", 32'(mem[0]), 32'hFF);
      chk("mem_511", 32'(mem[511]), 32'hFF);
      chk("mem_1023", 32'(mem[1023]), 32'hFF);
      $display("clear: %0d fill writes observed", DEPTH);

      // CPU pass-through write then read.
      cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0123; cpu_dout = 8'h3C;
      e.a = 16'h0123; e.d = 8'h3C; exp_q.push_back(e);
      #1;
      chk("pass_ram_cs", 32'(ram_cs), 1);
      chk("pass_ram_rw", 32'(ram_rw), 0);
      chk("pass_ram_din", 32'(ram_din), 32'h3C);
      $display("cpu write: addr 0123 data 3C");
      tick();
      cpu_rw = 1'b1; cpu_addr = 16'h0123;
      #1;
      chk("pass_read_rw", 32'(ram_rw), 1);
      chk("pass_read_addr", 32'(ram_addr), 32'h0123);
      chk("pass_read_data", 32'(mem[16'h0123]), 32'h3C);
      $display("cpu read: addr 0123 data %h", mem[16'h0123]);
      tick();
      cpu_cs = 1'b0;

      // Normal three-byte download.
      dl = 1'b1;
      tick();
      chk("load_cpu_rdy", 32'(cpu_rdy), 0);
      send_byte(16'h0200, 8'hA9, 1'b1);
      send_byte(16'h0201, 8'h00, 1'b1);
      send_byte(16'h0202, 8'h8D, 1'b1);
      end_download("dl1");
      chk("dl1_count", 32'(count), 3);
      chk("dl1_err", 32'(err), 0);
      chk("dl1_mem200", 32'(mem[16'h0200]), 32'hA9);
      chk("dl1_mem201", 32'(mem[16'h0201]), 32'h00);
      chk("dl1_mem202", 32'(mem[16'h0202]), 32'h8D);

      // Out-of-range byte followed by an overrun strobe while wait is high.
      dl = 1'b1;
      tick();
      send_byte(16'h0400, 8'h55, 1'b0);
      chk("oor_wait_high", 32'(io_wait), 1);
      wr = 1'b1; io_addr = 16'h0010; io_dout = 8'h77;
      $display("ioctl byte: addr 0010 data 77 issued while ioctl_wait=1");
      tick();
      wr = 1'b0;
      chk("oor_err_set", 32'(err), 1);
      chk("oor_count_zero", 32'(count), 0);
      send_byte(16'h0005, 8'h11, 1'b1);
      end_download("dl2");
      chk("dl2_count", 32'(count), 1);
      chk("dl2_err_sticky", 32'(err), 1);
      chk("dl2_mem010", 32'(mem[16'h0010]), 32'hFF);
      chk("dl2_mem005", 32'(mem[16'h0005]), 32'h11);

      // New download clears the error; reset arrives after two bytes.
      dl = 1'b1;
      tick();
      chk("dl3_err_cleared", 32'(err), 0);
      chk("dl3_count_cleared", 32'(count), 0);
      send_byte(16'h0020, 8'h01, 1'b1);
      send_byte(16'h0021, 8'h02, 1'b1);
      tick();
      chk("dl3_count_two", 32'(count), 2);
      tick();
      rst_n = 1'b0;
      dl = 1'b0;
      #1;
      reset_checks("midload_reset");
      $display("reset pulsed mid-load");
      tick();

      // Fresh clear with a download request raised at edge 10.
      push_clear();
      rst_n = 1'b1;
      repeat (9) tick();
      chk("clr10_wait_before", 32'(io_wait), 0);
      dl = 1'b1;
      #1;
      chk("clr10_wait_now", 32'(io_wait), 1);
      bad = 0;
      repeat (DEPTH - 9) begin
         tick();
         if (io_wait !== 1'b1 || cpu_rdy !== 1'b0) bad++;
      end
      chk("clr10_wait_held_cycles", 32'(bad), 0);
      tick();
      chk("clr10_pass_wait", 32'(io_wait), 1);
      tick();
      chk("clr10_load_cpu_rdy", 32'(cpu_rdy), 0);
      chk("clr10_load_wait", 32'(io_wait), 0);
      chk("clr10_writes_left", exp_q.size(), 0);
      chk("clr10_mem200", 32'(mem[16'h0200]), 32'hFF);
      chk("clr10_mem020", 32'(mem[16'h0020]), 32'hFF);
      chk("clr10_mem3ff", 32'(mem[16'h03FF]), 32'hFF);
      end_download("dl4");
      chk("dl4_count", 32'(count), 0);

      repeat (2) tick();
      chk("final_queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
